// File: rtl/uart_rx_fifo_if.sv
// Receive-word handshake between uart_rx_fifo (master) and its consumer (slave).
interface uart_rx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] dout;
  logic                 dout_perr;
  logic                 dout_ferr;
  logic                 dout_valid;
  logic                 dout_ready;

  modport master (output dout, dout_perr, dout_ferr, dout_valid, input dout_ready);
  modport slave  (input dout, dout_perr, dout_ferr, dout_valid, output dout_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority vote, false-start rejection,
// per-word parity/framing flags and a first-word-fall-through output FIFO.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  uart_rx_fifo_if.master              word,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun,
  input  logic                        clr_err,
  output logic                        busy,
  output logic [4:0]                  state_out
);
  localparam int TICK_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int M        = OVERSAMPLE / 2;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_V0      = SW'(M - 1);
  localparam logic [SW-1:0] S_V1      = SW'(M);
  localparam logic [SW-1:0] S_V2      = SW'(M + 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  // Encodings double as the one-hot LED debug value.
  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    START   = 5'b00010,
    DATA    = 5'b00100,
    PAR_BIT = 5'b01000,
    STOP    = 5'b10000
  } state_t;

  typedef struct packed {
    logic                 perr;
    logic                 ferr;
    logic [DATA_BITS-1:0] data;
  } word_t;

  state_t               state, state_n;
  logic                 rx_m, rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [SW-1:0]        s;
  logic                 tick, vote_tick, end_tick;
  logic                 v0, v1, vote;
  logic                 armed;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr, ferr_now;
  logic                 push, frame_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign tick      = (state != IDLE) && (tick_cnt == TICK_LAST);
  assign vote_tick = tick && (s == S_V2);
  assign end_tick  = tick && (s == S_LAST);
  assign vote      = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

  // Both counters sit at zero in IDLE, so every frame starts bit-aligned to its start edge.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) begin
      tick_cnt <= '0;
      s        <= '0;
    end else begin
      // NOTE: sequential state always uses <=, so every flop samples pre-edge values.
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) s <= (s == S_LAST) ? '0 : s + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_n     = state;
    push        = 1'b0;
    frame_start = 1'b0;
    ferr_now    = ferr | ~vote;
    unique case (state)
      IDLE: begin
        if (armed && !rx_s) begin
          state_n     = START;
          frame_start = 1'b1;
        end
      end
      START: begin
        if (vote_tick && vote) state_n = IDLE;
        else if (end_tick)     state_n = DATA;
      end
      DATA: begin
        if (end_tick && bit_cnt == BIT_LAST) begin
          if (PARITY != 0) state_n = PAR_BIT;
          else             state_n = STOP;
        end
      end
      PAR_BIT: begin
        if (end_tick) state_n = STOP;
      end
      STOP: begin
        // Leave mid-bit on the final stop so the next start edge is never missed.
        if (vote_tick && stop_cnt == STOP_LAST) begin
          state_n = IDLE;
          push    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed    <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      v0       <= 1'b1;
      v1       <= 1'b1;
    end else begin
      // armed needs a high line before each start, so a held-low break cannot retrigger.
      if (frame_start)                armed <= 1'b0;
      else if (state == IDLE && rx_s) armed <= 1'b1;
      if (frame_start) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        perr     <= 1'b0;
        ferr     <= 1'b0;
      end
      if (tick && s == S_V0) v0 <= rx_s;
      if (tick && s == S_V1) v1 <= rx_s;
      if (state == DATA && vote_tick)    shreg    <= {vote, shreg[DATA_BITS-1:1]};
      if (state == DATA && end_tick)     bit_cnt  <= bit_cnt + 4'd1;
      if (state == PAR_BIT && vote_tick) perr     <= ((^shreg) ^ vote) != PAR_ODD;
      if (state == STOP && vote_tick)    ferr     <= ferr_now;
      if (state == STOP && end_tick)     stop_cnt <= stop_cnt + 1'b1;
    end
  end

  word_t         mem [FIFO_DEPTH];
  word_t         head;
  logic [AW-1:0] wptr, rptr;
  logic          full, pop, push_ok;

  assign full    = (fifo_count == CNT_FULL);
  assign pop     = word.dout_valid & word.dout_ready;
  assign push_ok = push & (~full | pop);

  // NOTE: storage is not reset; the count gates visibility, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= {perr, ferr_now, shreg};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (push_ok && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push_ok && pop) fifo_count <= fifo_count - 1'b1;
      if (push && full && !pop) overrun <= 1'b1;
      else if (clr_err)         overrun <= 1'b0;
    end
  end

  assign head            = mem[rptr];
  assign word.dout_valid = (fifo_count != '0);
  assign word.dout       = word.dout_valid ? head.data : '0;
  assign word.dout_perr  = word.dout_valid & head.perr;
  assign word.dout_ferr  = word.dout_valid & head.ferr;

  assign busy      = (state != IDLE);
  assign state_out = state;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench: an 8N1 and an 8E2 receiver driven by directed frames and
// random traffic, with expected words kept in a queue model.
module tb_uart_rx_fifo;
  localparam int CLK_HZ   = 1_600_000;
  localparam int BAUD     = 50_000;
  localparam int OS       = 16;
  localparam int TICK_DIV = CLK_HZ / (BAUD * OS);
  localparam int BIT      = TICK_DIV * OS;
  localparam int M        = OS / 2;

  logic       clk = 1'b0;
  logic       rst, clr_err, rx_a, rx_b;
  logic [2:0] count_a, count_b;
  logic       overrun_a, overrun_b, busy_a, busy_b;
  logic [4:0] state_a, state_b;
  int         n_checks = 0;
  int         n_bad = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DATA_BITS(8)) if_a ();
  uart_rx_fifo_if #(.DATA_BITS(8)) if_b ();

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .rx(rx_a), .word(if_a), .fifo_count(count_a),
    .overrun(overrun_a), .clr_err(clr_err), .busy(busy_a), .state_out(state_a));

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
                 .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .rx(rx_b), .word(if_b), .fifo_count(count_b),
    .overrun(overrun_b), .clr_err(clr_err), .busy(busy_b), .state_out(state_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic line(input int chan, input logic v, input int cycles);
    if (chan == 0) rx_a = v;
    else           rx_b = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input int chan, input logic [7:0] data, input logic par_en,
                            input logic par_bit, input logic [1:0] stops, input int nstop);
    line(chan, 1'b0, BIT);
    for (int i = 0; i < 8; i++) line(chan, data[i], BIT);
    if (par_en) line(chan, par_bit, BIT);
    for (int i = 0; i < nstop; i++) line(chan, stops[i], BIT);
  endtask

  function automatic logic valid_of(input int chan);
    return (chan == 0) ? if_a.dout_valid : if_b.dout_valid;
  endfunction

  function automatic logic [9:0] head_of(input int chan);
    return (chan == 0) ? {if_a.dout_perr, if_a.dout_ferr, if_a.dout}
                       : {if_b.dout_perr, if_b.dout_ferr, if_b.dout};
  endfunction

  task automatic set_ready(input int chan, input logic v);
    if (chan == 0) if_a.dout_ready = v;
    else           if_b.dout_ready = v;
  endtask

  task automatic pop_check(input int chan, input string tag, input logic [9:0] exp);
    check({tag, "_valid"}, valid_of(chan), 1'b1);
    check(tag, head_of(chan), exp);
    set_ready(chan, 1'b1);
    @(negedge clk);
    set_ready(chan, 1'b0);
  endtask

  // Random frames with a randomly stalling consumer; expected words come from the frame contents.
  task automatic run_random(input int chan, input int frames);
    logic stop_cons;
    stop_cons = 1'b0;
    exp_q.delete();
    fork
      begin
        for (int f = 0; f < frames; f++) begin
          logic [7:0] d;
          logic       p;
          logic [1:0] st;
          d     = 8'($urandom_range(0, 255));
          st[0] = ($urandom_range(0, 4) != 0);
          st[1] = ($urandom_range(0, 4) != 0);
          if (chan == 0) begin
            exp_q.push_back({1'b0, ~st[0], d});
            send_frame(0, d, 1'b0, 1'b0, st, 1);
          end else begin
            p = (^d) ^ ($urandom_range(0, 3) == 0);
            exp_q.push_back({(^d) ^ p, ~(st[0] & st[1]), d});
            send_frame(1, d, 1'b1, p, st, 2);
          end
          line(chan, 1'b1, $urandom_range(4, 40));
        end
        for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(negedge clk);
        check("rand_drain", exp_q.size(), 0);
        stop_cons = 1'b1;
      end
      begin
        while (!stop_cons) begin
          logic r;
          @(negedge clk);
          r = 1'($urandom_range(0, 1));
          set_ready(chan, r);
          if (valid_of(chan) && r) begin
            check("rand_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("rand_word", head_of(chan), exp_q.pop_front());
          end
        end
      end
    join
    set_ready(chan, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [7:0] d5a;
    rst = 1'b1; clr_err = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    if_a.dout_ready = 1'b0;
    if_b.dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_word", head_of(0), 10'h000);
    check("rst_valid", if_a.dout_valid, 1'b0);
    check("rst_count", count_a, 3'd0);
    check("rst_overrun", overrun_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_state", state_a, 5'b00001);
    check("rst_state_b", state_b, 5'b00001);
    repeat (4) @(negedge clk);

    // 0xA5 8N1: valid appears after 2 sync + 1 detect cycles plus 9 bits and M+2 ticks.
    lat = 0;
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 2'b11, 1);
      while (!if_a.dout_valid && lat < 20 * BIT) begin
        @(negedge clk);
        lat++;
      end
    join
    check("a5_latency", lat, 3 + TICK_DIV * (9 * OS + M + 2));
    check("a5_count", count_a, 3'd1);
    pop_check(0, "a5_word", {2'b00, 8'hA5});
    check("a5_empty", count_a, 3'd0);

    // Short glitch: rejected by the start-bit vote.
    line(0, 1'b0, 6);
    line(0, 1'b1, 4);
    check("fs_busy", busy_a, 1'b1);
    line(0, 1'b1, BIT);
    check("fs_state", state_a, 5'b00001);
    check("fs_count", count_a, 3'd0);

    // Framing error followed by a held-low break.
    send_frame(0, 8'h3C, 1'b0, 1'b0, 2'b00, 1);
    line(0, 1'b0, 3 * BIT);
    check("brk_count", count_a, 3'd1);
    check("brk_state", state_a, 5'b00001);
    line(0, 1'b1, 8);
    send_frame(0, 8'hC3, 1'b0, 1'b0, 2'b11, 1);
    line(0, 1'b1, 4);
    check("brk_count2", count_a, 3'd2);
    pop_check(0, "brk_word", {2'b01, 8'h3C});
    pop_check(0, "brk_next", {2'b00, 8'hC3});

    // Even parity: 0x07 has three ones, so the parity bit must be 1.
    send_frame(1, 8'h07, 1'b1, 1'b0, 2'b11, 2);
    line(1, 1'b1, 4);
    send_frame(1, 8'h07, 1'b1, 1'b1, 2'b11, 2);
    line(1, 1'b1, 4);
    check("par_count", count_b, 3'd2);
    pop_check(1, "par_bad", {2'b10, 8'h07});
    pop_check(1, "par_good", {2'b00, 8'h07});

    // Overrun: fifth word dropped, earlier four intact, flag sticky until cleared.
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b0, 2'b11, 1);
    line(0, 1'b1, 4);
    check("ovr_count", count_a, 3'd4);
    check("ovr_flag", overrun_a, 1'b1);
    for (int i = 1; i <= 4; i++) pop_check(0, "ovr_pop", {2'b00, 8'(i)});
    check("ovr_empty", count_a, 3'd0);
    check("ovr_sticky", overrun_a, 1'b1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("ovr_clr", overrun_a, 1'b0);

    // Reset in the middle of DATA bit 4 discards the FIFO and the partial word.
    send_frame(0, 8'h11, 1'b0, 1'b0, 2'b11, 1);
    line(0, 1'b1, 4);
    check("mr_pre_count", count_a, 3'd1);
    d5a = 8'h5A;
    line(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) line(0, d5a[i], BIT);
    line(0, d5a[4], BIT / 2);
    check("mr_in_data", state_a, 5'b00100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_state", state_a, 5'b00001);
    check("mr_count", count_a, 3'd0);
    line(0, 1'b1, 2 * BIT);
    check("mr_idle_count", count_a, 3'd0);
    send_frame(0, d5a, 1'b0, 1'b0, 2'b11, 1);
    line(0, 1'b1, 4);
    check("mr_new_count", count_a, 3'd1);
    pop_check(0, "mr_word", {2'b00, 8'h5A});

    run_random(0, 25);
    run_random(1, 20);
    check("end_overrun_a", overrun_a, 1'b0);
    check("end_overrun_b", overrun_b, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
